// File: rtl/pll_pkg.sv
// Shared types and constants for the EHXPLLL fabric controller.
package pll_pkg;

  typedef enum logic [2:0] {
    RESET,
    WAIT_LOCK,
    LOCKED,
    SETUP,
    PULSE,
    GAP
  } pll_state_e;

  localparam logic [1:0] SEL_CLKOP  = 2'd0;
  localparam logic [1:0] SEL_CLKOS  = 2'd1;
  localparam logic [1:0] SEL_CLKOS2 = 2'd2;
  localparam logic [1:0] SEL_CLKOS3 = 2'd3;

  localparam logic DIR_DELAY   = 1'b0;
  localparam logic DIR_ADVANCE = 1'b1;

  typedef struct packed {
    logic [1:0] sel;
    logic       dir;
  } phase_cfg_t;

  function automatic int unsigned max_of(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/pll_ctrl_if.sv
// Phase-step request channel: valid/ready request plus completion pulse.
interface pll_ctrl_if #(parameter int STEP_W = 8);
  logic              req_valid;
  logic              req_ready;
  logic [1:0]        req_sel;
  logic              req_dir;
  logic [STEP_W-1:0] req_steps;
  logic              req_done;

  modport master (output req_valid, req_sel, req_dir, req_steps,
                  input  req_ready, req_done);
  modport slave  (input  req_valid, req_sel, req_dir, req_steps,
                  output req_ready, req_done);
endinterface

// File: rtl/pll_lock_sync.sv
// LOCK synchronizer; with PLL_LOCK_FILTER_EN defined, acquisition also needs
// LOCK_STABLE consecutive high samples.
module pll_lock_sync #(
  parameter int LOCK_STABLE = 256
) (
  input  logic clk,
  input  logic rst_n,
  input  logic pll_lock_i,
  output logic lock_s_o,
  output logic lock_ok_o
);

  logic [1:0] sync_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sync_q <= '0;
    else        sync_q <= {sync_q[0], pll_lock_i};
  end

  assign lock_s_o = sync_q[1];

`ifdef PLL_LOCK_FILTER_EN
  localparam int SW = (LOCK_STABLE > 1) ? $clog2(LOCK_STABLE) : 1;
  localparam logic [SW-1:0] STAB_MAX = SW'(LOCK_STABLE - 1);

  logic [SW-1:0] stab_q;

  // Counts prior high samples; qualification needs the current one high too.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)                stab_q <= '0;
    else if (!lock_s_o)        stab_q <= '0;
    else if (stab_q != STAB_MAX) stab_q <= stab_q + 1'b1;
  end

  assign lock_ok_o = lock_s_o && (stab_q == STAB_MAX);
`else
  assign lock_ok_o = lock_s_o & (LOCK_STABLE >= 1);
`endif

endmodule

// File: rtl/pll_ctrl.sv
// EHXPLLL reset/lock sequencer with dynamic phase-step port.
// Optional lock stability filter: define PLL_LOCK_FILTER_EN.
module pll_ctrl import pll_pkg::*; #(
  parameter int RST_CYCLES   = 16,
  parameter int LOCK_TIMEOUT = 4096,
  parameter int STEP_SETUP   = 2,
  parameter int STEP_PULSE   = 2,
  parameter int STEP_GAP     = 4,
  parameter int STEP_W       = 8,
  parameter int LOCK_STABLE  = 256
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_lock,
  output logic       pll_rst,
  output logic [1:0] phasesel,
  output logic       phasedir,
  output logic       phasestep,
  output logic       locked,
  output logic [7:0] retry_cnt,
  pll_ctrl_if.slave  req
);

  localparam int unsigned T_MAX = max_of(max_of(RST_CYCLES, LOCK_TIMEOUT),
                                         max_of(STEP_SETUP, max_of(STEP_PULSE, STEP_GAP)));
  localparam int CNT_W = $clog2(T_MAX + 1);

  localparam logic [CNT_W-1:0] RST_LAST   = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] TO_LAST    = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] SETUP_LAST = CNT_W'(STEP_SETUP - 1);
  localparam logic [CNT_W-1:0] PULSE_LAST = CNT_W'(STEP_PULSE - 1);
  localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(STEP_GAP - 1);

  pll_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  phase_cfg_t        cfg_q, cfg_d;
  logic [STEP_W-1:0] rem_q, rem_d;
  logic [7:0]        retry_q, retry_d;
  logic              done_q, done_d;
  logic              lock_s, lock_ok, accept;

  pll_lock_sync #(.LOCK_STABLE(LOCK_STABLE)) u_lock_sync (
    .clk        (clk),
    .rst_n      (rst_n),
    .pll_lock_i (pll_lock),
    .lock_s_o   (lock_s),
    .lock_ok_o  (lock_ok)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= RESET;
      cnt_q   <= '0;
      cfg_q   <= '0;
      rem_q   <= '0;
      retry_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      cfg_q   <= cfg_d;
      rem_q   <= rem_d;
      retry_q <= retry_d;
      done_q  <= done_d;
    end
  end

  assign accept = req.req_valid && (state_q == LOCKED) && lock_s;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q + 1'b1;
    cfg_d   = cfg_q;
    rem_d   = rem_q;
    retry_d = retry_q;
    done_d  = 1'b0;
    case (state_q)
      RESET: if (cnt_q == RST_LAST) begin
        state_d = WAIT_LOCK;
        cnt_d   = '0;
      end
      WAIT_LOCK: begin
        if (lock_ok) begin
          state_d = LOCKED;
          cnt_d   = '0;
        end else if (cnt_q == TO_LAST) begin
          state_d = RESET;
          cnt_d   = '0;
          if (retry_q != 8'hFF) retry_d = retry_q + 8'd1;
        end
      end
      LOCKED: begin
        cnt_d = '0;
        if (accept) begin
          rem_d = req.req_steps;
          // Zero-step requests complete in place and leave the phase pins alone.
          if (req.req_steps == '0) begin
            done_d = 1'b1;
          end else begin
            cfg_d   = '{sel: req.req_sel, dir: req.req_dir};
            state_d = SETUP;
          end
        end
      end
      SETUP: if (cnt_q == SETUP_LAST) begin
        state_d = PULSE;
        cnt_d   = '0;
      end
      PULSE: if (cnt_q == PULSE_LAST) begin
        state_d = GAP;
        cnt_d   = '0;
        rem_d   = rem_q - 1'b1;
      end
      GAP: if (cnt_q == GAP_LAST) begin
        cnt_d = '0;
        if (rem_q != '0) begin
          state_d = PULSE;
        end else begin
          state_d = LOCKED;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = RESET;
        cnt_d   = '0;
      end
    endcase
    // Lock loss aborts any request silently; it is not a timeout retry.
    if ((state_q inside {LOCKED, SETUP, PULSE, GAP}) && !lock_s) begin
      state_d = RESET;
      cnt_d   = '0;
      cfg_d   = cfg_q;
      done_d  = 1'b0;
    end
  end

  always_comb begin
    pll_rst       = (state_q == RESET);
    locked        = state_q inside {LOCKED, SETUP, PULSE, GAP};
    req.req_ready = (state_q == LOCKED) && lock_s;
    phasestep     = (state_q == PULSE);
    phasesel      = cfg_q.sel;
    phasedir      = cfg_q.dir;
    req.req_done  = done_q;
    retry_cnt     = retry_q;
  end

endmodule

// File: tb/tb_pll_ctrl.sv
// Scenario bench for pll_ctrl; request completions are checked via a scoreboard.
module tb_pll_ctrl;

  localparam int RST_C = 16;
  localparam int TO    = 64;
  localparam int SS    = 2;
  localparam int SP    = 2;
  localparam int SG    = 4;
  localparam int SW    = 8;
  localparam int LS    = 8;
`ifdef PLL_LOCK_FILTER_EN
  localparam int LOCK_LAT = 2 + LS - 1;
`else
  localparam int LOCK_LAT = 2;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       pll_lock;
  logic       pll_rst;
  logic [1:0] phasesel;
  logic       phasedir;
  logic       phasestep;
  logic       locked;
  logic [7:0] retry_cnt;

  pll_ctrl_if #(.STEP_W(SW)) rq();

  pll_ctrl #(
    .RST_CYCLES(RST_C), .LOCK_TIMEOUT(TO), .STEP_SETUP(SS), .STEP_PULSE(SP),
    .STEP_GAP(SG), .STEP_W(SW), .LOCK_STABLE(LS)
  ) dut (
    .clk(clk), .rst_n(rst_n), .pll_lock(pll_lock), .pll_rst(pll_rst),
    .phasesel(phasesel), .phasedir(phasedir), .phasestep(phasestep),
    .locked(locked), .retry_cnt(retry_cnt), .req(rq)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         done_cyc;
    logic [1:0] sel;
    logic       dir;
  } exp_t;
  exp_t sb[$];

  int total = 0;
  int bad   = 0;
  logic [1:0] cur_sel = 2'd0;
  logic       cur_dir = 1'b0;

  localparam logic [15:0] RST_VEC = 16'h8000;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for ready, lets one edge accept, and records the expected completion.
  task automatic accept_req(input logic [1:0] s, input logic d, input logic [SW-1:0] n,
                            output int acc, output bit ok);
    exp_t e;
    ok = 1'b0;
    acc = 0;
    rq.req_valid = 1'b1;
    rq.req_sel   = s;
    rq.req_dir   = d;
    rq.req_steps = n;
    for (int i = 0; i < 200; i++) begin
      if (rq.req_ready) begin
        tick();
        acc = cyc;
        ok  = 1'b1;
        break;
      end
      tick();
    end
    rq.req_valid = 1'b0;
    if (ok) begin
      if (n != '0) begin
        cur_sel = s;
        cur_dir = d;
      end
      e.done_cyc = (n == '0) ? acc : acc + SS + int'(n) * (SP + SG);
      e.sel      = cur_sel;
      e.dir      = cur_dir;
      sb.push_back(e);
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    pll_lock = 1'b0;
    rq.req_valid = 1'b0;
    rq.req_sel = 2'd0;
    rq.req_dir = 1'b0;
    rq.req_steps = '0;
    repeat (3) tick();
    total++;
    if ({pll_rst, phasesel, phasedir, phasestep, locked, rq.req_ready, rq.req_done, retry_cnt} !== RST_VEC) begin
      bad++;
      $display("FAIL reset_values: got %h want %h",
        {pll_rst, phasesel, phasedir, phasestep, locked, rq.req_ready, rq.req_done, retry_cnt}, RST_VEC);
    end
  endtask

  task automatic test_acquire();
    int n = 0;
    int k = 0;
    rst_n = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (!pll_rst) break;
      n++;
      tick();
    end
    total++;
    if (n !== RST_C) begin bad++; $display("FAIL rst_pulse_len: got %0d want %0d", n, RST_C); end
    repeat (40 - RST_C) tick();
    pll_lock = 1'b1;
    tick();
    for (int i = 0; i < 100; i++) begin
      if (locked) break;
      tick();
      k++;
    end
    total++;
    if (k !== LOCK_LAT) begin bad++; $display("FAIL lock_latency: got %0d want %0d", k, LOCK_LAT); end
    total++;
    if ({pll_rst, rq.req_ready, retry_cnt} !== {1'b0, 1'b1, 8'd0}) begin
      bad++;
      $display("FAIL locked_state: rst=%b ready=%b retry=%0d want 0 1 0", pll_rst, rq.req_ready, retry_cnt);
    end
  endtask

  task automatic test_phase_step();
    int acc;
    bit ok;
    int wave_err = 0;
    int rdy_err = 0;
    int rises = 0;
    int ndone = 0;
    logic prev = 1'b0;
    exp_t e;
    accept_req(2'd2, 1'b1, 8'd3, acc, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL step_accept: ready never seen"); return; end
    total++;
    if ({phasesel, phasedir} !== {2'd2, 1'b1}) begin
      bad++; $display("FAIL step_sel_dir: got %0d/%0d want 2/1", phasesel, phasedir);
    end
    for (int k = 0; k <= 24; k++) begin
      logic exp_ps;
      exp_ps = (k >= SS) && (k < SS + 3 * (SP + SG)) && (((k - SS) % (SP + SG)) < SP);
      if (phasestep !== exp_ps) wave_err++;
      if (rq.req_ready !== (k >= SS + 3 * (SP + SG))) rdy_err++;
      if (phasestep && !prev) rises++;
      prev = phasestep;
      if (rq.req_done) begin
        ndone++;
        total++;
        if (sb.size() == 0) begin
          bad++; $display("FAIL step_done: unexpected done at cycle %0d", cyc);
        end else begin
          e = sb.pop_front();
          if (cyc !== e.done_cyc || phasesel !== e.sel || phasedir !== e.dir) begin
            bad++;
            $display("FAIL step_done: cyc=%0d sel=%0d dir=%b want cyc=%0d sel=%0d dir=%b",
              cyc, phasesel, phasedir, e.done_cyc, e.sel, e.dir);
          end
        end
      end
      tick();
    end
    total++;
    if (wave_err !== 0) begin bad++; $display("FAIL step_wave: %0d wrong phasestep cycles want 0", wave_err); end
    total++;
    if (rises !== 3) begin bad++; $display("FAIL step_count: got %0d pulses want 3", rises); end
    total++;
    if (rdy_err !== 0) begin bad++; $display("FAIL step_ready: %0d wrong ready cycles want 0", rdy_err); end
    total++;
    if (ndone !== 1) begin bad++; $display("FAIL step_done_cnt: got %0d want 1", ndone); end
  endtask

  task automatic test_zero_steps();
    int acc;
    bit ok;
    int ps_err = 0;
    int rdy_err = 0;
    int ndone = 0;
    exp_t e;
    accept_req(2'd1, 1'b0, 8'd0, acc, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL zero_accept: ready never seen"); return; end
    for (int k = 0; k < 10; k++) begin
      if (phasestep !== 1'b0) ps_err++;
      if (rq.req_ready !== 1'b1) rdy_err++;
      if (rq.req_done) begin
        ndone++;
        total++;
        e = sb.pop_front();
        if (cyc !== e.done_cyc || phasesel !== e.sel || phasedir !== e.dir) begin
          bad++;
          $display("FAIL zero_done: cyc=%0d sel=%0d dir=%b want cyc=%0d sel=%0d dir=%b",
            cyc, phasesel, phasedir, e.done_cyc, e.sel, e.dir);
        end
      end
      tick();
    end
    total++;
    if (ndone !== 1 || ps_err !== 0 || rdy_err !== 0) begin
      bad++;
      $display("FAIL zero_quiet: done=%0d step_err=%0d ready_err=%0d want 1 0 0", ndone, ps_err, rdy_err);
    end
  endtask

  task automatic test_back_to_back();
    logic [1:0]    s_t[3] = '{2'd0, 2'd3, 2'd1};
    logic          d_t[3] = '{1'b0, 1'b1, 1'b1};
    logic [SW-1:0] n_t[3] = '{8'd1, 8'd2, 8'd0};
    int acc;
    bit ok;
    bit got;
    exp_t e;
    for (int r = 0; r < 3; r++) begin
      accept_req(s_t[r], d_t[r], n_t[r], acc, ok);
      got = 1'b0;
      for (int k = 0; k < 100 && ok; k++) begin
        if (rq.req_done) begin
          got = 1'b1;
          total++;
          e = sb.pop_front();
          if (cyc !== e.done_cyc || phasesel !== e.sel || phasedir !== e.dir) begin
            bad++;
            $display("FAIL b2b_done[%0d]: cyc=%0d sel=%0d dir=%b want cyc=%0d sel=%0d dir=%b",
              r, cyc, phasesel, phasedir, e.done_cyc, e.sel, e.dir);
          end
          break;
        end
        tick();
      end
      total++;
      if (!got) begin bad++; $display("FAIL b2b_timeout[%0d]: no done want done", r); end
    end
    total++;
    if (sb.size() !== 0) begin bad++; $display("FAIL b2b_leftover: %0d pending want 0", sb.size()); end
  endtask

  task automatic test_lock_loss();
    int acc;
    bit ok;
    int spurious = 0;
    int n = 0;
    bit relock = 1'b0;
    bit got = 1'b0;
    exp_t e;
    accept_req(2'd1, 1'b0, 8'd5, acc, ok);
    total++;
    if (!ok) begin bad++; $display("FAIL loss_accept: ready never seen"); return; end
    for (int k = 0; k < 8; k++) begin
      if (rq.req_done) spurious++;
      tick();
    end
    total++;
    if (phasestep !== 1'b1) begin bad++; $display("FAIL loss_in_pulse: phasestep=%b want 1", phasestep); end
    pll_lock = 1'b0;
    sb.delete();
    repeat (3) begin
      tick();
      if (rq.req_done) spurious++;
    end
    total++;
    if ({locked, phasestep, pll_rst} !== 3'b001) begin
      bad++; $display("FAIL loss_react: locked=%b step=%b rst=%b want 0 0 1", locked, phasestep, pll_rst);
    end
    for (int i = 0; i < 100; i++) begin
      if (!pll_rst) break;
      if (rq.req_done) spurious++;
      n++;
      tick();
    end
    total++;
    if (n !== RST_C) begin bad++; $display("FAIL loss_rst_len: got %0d want %0d", n, RST_C); end
    total++;
    if (retry_cnt !== 8'd0 || spurious !== 0) begin
      bad++; $display("FAIL loss_side: retry=%0d done=%0d want 0 0", retry_cnt, spurious);
    end
    pll_lock = 1'b1;
    for (int i = 0; i < 100; i++) begin
      if (locked) begin relock = 1'b1; break; end
      tick();
    end
    total++;
    if (!relock) begin bad++; $display("FAIL loss_relock: locked=0 want 1"); return; end
    accept_req(2'd1, 1'b0, 8'd5, acc, ok);
    for (int k = 0; k < 100 && ok; k++) begin
      if (rq.req_done) begin
        got = 1'b1;
        e = sb.pop_front();
        total++;
        if (cyc !== e.done_cyc || phasesel !== e.sel) begin
          bad++; $display("FAIL reissue_done: cyc=%0d sel=%0d want cyc=%0d sel=%0d", cyc, phasesel, e.done_cyc, e.sel);
        end
        break;
      end
      tick();
    end
    total++;
    if (!got) begin bad++; $display("FAIL reissue_timeout: no done want done"); end
  endtask

`ifdef PLL_LOCK_FILTER_EN
  task automatic test_filter();
    int rise_at = -1;
    int early = 0;
    pll_lock = 1'b0;
    for (int i = 0; i < 20 && !pll_rst; i++) tick();
    for (int i = 0; i < 40 && pll_rst; i++) tick();
    pll_lock = 1'b1;
    repeat (5) begin tick(); if (locked) early++; end
    pll_lock = 1'b0;
    tick();
    if (locked) early++;
    pll_lock = 1'b1;
    for (int m = 1; m <= 40; m++) begin
      tick();
      if (locked && rise_at < 0) rise_at = m;
    end
    total++;
    if (early !== 0) begin bad++; $display("FAIL filter_glitch: locked high %0d cycles want 0", early); end
    total++;
    if (rise_at !== 1 + LOCK_LAT) begin bad++; $display("FAIL filter_rise: got %0d want %0d", rise_at, 1 + LOCK_LAT); end
  endtask
`endif

  task automatic test_async_reset();
    int acc;
    bit ok;
    bit relock = 1'b0;
    accept_req(2'd3, 1'b1, 8'd4, acc, ok);
    repeat (5) tick();
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    sb.delete();
    cur_sel = 2'd0;
    cur_dir = 1'b0;
    total++;
    if ({pll_rst, phasesel, phasedir, phasestep, locked, rq.req_ready, rq.req_done, retry_cnt} !== RST_VEC) begin
      bad++;
      $display("FAIL async_reset: got %h want %h",
        {pll_rst, phasesel, phasedir, phasestep, locked, rq.req_ready, rq.req_done, retry_cnt}, RST_VEC);
    end
    repeat (2) tick();
    rst_n = 1'b1;
    for (int i = 0; i < 200; i++) begin
      if (locked) begin relock = 1'b1; break; end
      tick();
    end
    total++;
    if (!relock || retry_cnt !== 8'd0) begin
      bad++; $display("FAIL async_relock: locked=%b retry=%0d want 1 0", relock, retry_cnt);
    end
  endtask

  task automatic test_timeout();
    int n_lo;
    int n_hi;
    pll_lock = 1'b0;
    for (int i = 0; i < 20 && !pll_rst; i++) tick();
    for (int i = 0; i < 40 && pll_rst; i++) tick();
    total++;
    if (retry_cnt !== 8'd0) begin bad++; $display("FAIL to_loss_retry: got %0d want 0", retry_cnt); end
    for (int r = 1; r <= 3; r++) begin
      n_lo = 0;
      n_hi = 0;
      for (int i = 0; i < 200 && !pll_rst; i++) begin n_lo++; tick(); end
      total++;
      if (n_lo !== TO || retry_cnt !== 8'(r)) begin
        bad++; $display("FAIL to_wait[%0d]: wait=%0d retry=%0d want %0d %0d", r, n_lo, retry_cnt, TO, r);
      end
      for (int i = 0; i < 200 && pll_rst; i++) begin n_hi++; tick(); end
      total++;
      if (n_hi !== RST_C) begin bad++; $display("FAIL to_rst[%0d]: got %0d want %0d", r, n_hi, RST_C); end
    end
    for (int c = 0; c < 300 * (RST_C + TO) && retry_cnt != 8'hFF; c++) tick();
    repeat (3 * (RST_C + TO)) tick();
    total++;
    if (retry_cnt !== 8'hFF) begin bad++; $display("FAIL to_saturate: got %0d want 255", retry_cnt); end
  endtask

  initial begin
    test_reset();
    test_acquire();
    test_phase_step();
    test_zero_steps();
    test_back_to_back();
    test_lock_loss();
`ifdef PLL_LOCK_FILTER_EN
    test_filter();
    pll_lock = 1'b1;
    for (int i = 0; i < 200 && !locked; i++) tick();
`endif
    test_async_reset();
    test_timeout();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pll_ctrl.md
Name: pll_ctrl

Overview:
Fabric-side controller for the ECP5 EHXPLLL primitive. Sequences PLL reset and lock acquisition with timeout and retry. Owns the dynamic phase-adjust pins PHASESEL/PHASEDIR/PHASESTEP and accepts phase-step requests from one requester over a valid/ready handshake. Runs on a free-running reference clock, never on a PLL output, and sits beside the PLL instance in the clocking top level.

Parameters:
RST_CYCLES, 16, cycles pll_rst is held high per reset attempt (1..65535)
LOCK_TIMEOUT, 4096, cycles to wait for lock before re-issuing reset (1..2^20-1)
STEP_SETUP, 2, cycles phasesel/phasedir are stable before phasestep rises (>=1)
STEP_PULSE, 2, cycles phasestep is high (>=1)
STEP_GAP, 4, cycles phasestep is low between consecutive pulses (>=1)
STEP_W, 8, width of the step-count field
LOCK_STABLE, 256, lock-filter length; used only with PLL_LOCK_FILTER_EN

Ports:
clk  in  1  controller clock (reference-domain, free running)
rst_n  in  1  asynchronous active-low reset
pll_lock  in  1  LOCK from EHXPLLL, asynchronous to clk
pll_rst  out  1  to EHXPLLL RST
phasesel  out  2  to PHASESEL1:0
phasedir  out  1  to PHASEDIR
phasestep  out  1  to PHASESTEP
locked  out  1  qualified lock status
req_valid  in  1  phase-step request valid
req_ready  out  1  request accepted when valid&ready
req_sel  in  2  target output (0=CLKOP .. 3=CLKOS3)
req_dir  in  1  0=delay, 1=advance
req_steps  in  STEP_W  number of phase steps
req_done  out  1  one-cycle pulse when a request completes
retry_cnt  out  8  saturating count of lock-timeout retries

Behaviour:
- pll_lock passes through a 2-flop synchronizer (lock_s). All decisions use lock_s.
- Reset values: pll_rst=1, phasesel=0, phasedir=0, phasestep=0, locked=0, req_ready=0, req_done=0, retry_cnt=0. FSM is in RESET with its counter at 0.
- FSM states: RESET, WAIT_LOCK, LOCKED, SETUP, PULSE, GAP.
- RESET: pll_rst=1 for exactly RST_CYCLES cycles, then WAIT_LOCK.
- WAIT_LOCK: pll_rst=0.
  - On qualified lock -> LOCKED.
  - If the counter reaches LOCK_TIMEOUT with no lock -> RESET and retry_cnt+1, saturating at 255.
- LOCKED: locked=1, req_ready=1.
  - On valid&ready, latch sel/dir/steps.
  - If steps==0: req_done pulses the next cycle and the FSM stays in LOCKED.
  - Otherwise -> SETUP. req_ready=0 outside LOCKED.
- SETUP: drive phasesel/phasedir from the latch for STEP_SETUP cycles, then PULSE.
- PULSE: phasestep=1 for STEP_PULSE cycles. Decrement the remaining count on exit, then GAP.
- GAP: phasestep=0 for STEP_GAP cycles.
  - If remaining >0 -> PULSE (no re-setup).
  - Otherwise -> LOCKED with req_done=1 for one cycle.
- phasesel/phasedir hold their last values in LOCKED. They change only on SETUP entry.
- Lock loss: lock_s=0 in LOCKED/SETUP/PULSE/GAP immediately forces RESET on the next cycle.
  - locked=0, phasestep=0, the request is aborted with no req_done, and retry_cnt is unchanged.
- Aborted request: the requester re-issues it after locked returns.
- Asynchronous rst_n mid-operation returns all outputs to their reset values immediately.
- Step timing end-to-end: accept at cycle T. The first phasestep rise is at T+1+STEP_SETUP. N steps take STEP_SETUP + N*(STEP_PULSE+STEP_GAP) cycles before req_done.
- Counters must be sized with clog2 of the largest timing parameter. No counter wraps: each reloads on state entry.

Optional Feature:
PLL_LOCK_FILTER_EN
- Defined: lock is qualified only after lock_s has been continuously high for LOCK_STABLE cycles. Any low sample clears the filter. Loss of lock is still detected on the first low lock_s sample.
- Undefined: qualified lock equals lock_s, and LOCK_STABLE is ignored.

Decomposition:
- Shared package pll_pkg holds:
  - the state enum typedef (RESET..GAP)
  - phasesel encoding constants (SEL_CLKOP=0, SEL_CLKOS=1, SEL_CLKOS2=2, SEL_CLKOS3=3)
  - direction constants (DIR_DELAY=0, DIR_ADVANCE=1)
- One natural sub-module: pll_lock_sync. It contains the 2-flop synchronizer plus the optional stability filter and outputs the qualified lock and the raw lock_s.

Test Plan:
- Reset/acquire: defaults, pll_lock high at cycle 40 -> pll_rst high exactly 16 cycles after rst_n release; locked rises 2 cycles after lock is sampled (no filter); retry_cnt=0.
- Timeout/retry: LOCK_TIMEOUT=64, pll_lock held 0 -> pll_rst re-pulses every 16+64 cycles; retry_cnt counts 1,2,3 and saturates at 255 over a long run.
- Phase step: locked, request sel=2, dir=1, steps=3 -> phasesel=2 and phasedir=1 two cycles before the first rise; 3 phasestep pulses, each 2 high/4 low; req_done 20 cycles after accept; req_ready low throughout.
- Zero steps: request steps=0 -> no phasestep activity; req_done one cycle after accept; req_ready stays 1.
- Lock loss mid-step: drop pll_lock during the second pulse of a 5-step request -> phasestep=0 and locked=0 within 3 cycles of the drop; no req_done; pll_rst re-asserts for 16 cycles; retry_cnt unchanged.
- PLL_LOCK_FILTER_EN, LOCK_STABLE=8: lock glitches low for 1 cycle at 5 cycles high -> locked stays 0; locked rises only after 8 continuous high samples.
